// File: rtl/seq_logic_unit.sv
// Multi-cycle bitwise logic unit: operands latched on start, result built SLICE bits per cycle, LSB first.
// Define SEQ_LOGIC_UNIT_FLAGS_EN to add the parity and ones result flags.
module seq_logic_unit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
`ifdef SEQ_LOGIC_UNIT_FLAGS_EN
  ,
  output logic             parity,
  output logic             ones
`endif
);

  localparam int N = (SLICE > 0) ? (WIDTH / SLICE) : 1;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  if (SLICE < 1) begin : g_bad_slice
    $error("seq_logic_unit: SLICE must be at least 1");
  end else if ((WIDTH % SLICE) != 0) begin : g_bad_width
    $error("seq_logic_unit: WIDTH must be an integer multiple of SLICE");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [SLICE-1:0] logic_op(input logic [2:0] op_v,
                                                input logic [SLICE-1:0] x,
                                                input logic [SLICE-1:0] y);
    logic [SLICE-1:0] r;
    case (op_v)
      3'b000:  r = ~x;
      3'b001:  r = x & y;
      3'b010:  r = x | y;
      3'b011:  r = x ^ y;
      3'b100:  r = ~(x ^ y);
      3'b101:  r = ~(x & y);
      3'b110:  r = ~(x | y);
      3'b111:  r = x & ~y;
      default: r = {SLICE{1'b0}};
    endcase
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [2:0]       op_q, op_d;
  logic             zero_q, zero_d;
  logic             parity_q, parity_d, ones_q, ones_d;
  logic [31:0]      base_s;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 3'b000;
      result_q <= '0;
      zero_q   <= 1'b0;
      parity_q <= 1'b0;
      ones_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      parity_q <= parity_d;
      ones_q   <= ones_d;
    end
  end

  // Next-state and datapath update; flags are taken from the complete next result
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    zero_d   = zero_q;
    parity_d = parity_q;
    ones_d   = ones_q;
    base_s   = 32'(cnt_q) * 32'(SLICE);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          op_d     = op;
          cnt_d    = '0;
          result_d = '0;
          zero_d   = 1'b0;
          parity_d = 1'b0;
          ones_d   = 1'b0;
          state_d  = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        result_d[base_s +: SLICE] = logic_op(op_q, a_q[base_s +: SLICE], b_q[base_s +: SLICE]);
        if (cnt_q == CNT_LAST) begin
          zero_d   = (result_d == '0);
          parity_d = ^result_d;
          ones_d   = &result_d;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      ST_IDLE: ready = 1'b1;
      ST_RUN:  busy  = 1'b1;
      ST_DONE: done  = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign result = result_q;
  assign zero   = zero_q;

`ifdef SEQ_LOGIC_UNIT_FLAGS_EN
  assign parity = parity_q;
  assign ones   = ones_q;
`else
  logic unused_flags_s;
  assign unused_flags_s = parity_q ^ ones_q ^ parity_d ^ ones_d;
`endif

endmodule

// File: tb/tb_seq_logic_unit.sv
// Directed bench for seq_logic_unit: a 32/4 instance and an 8/8 (single RUN cycle) instance.
module tb_seq_logic_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = 32'h0, b = 32'h0;
  logic        ready, busy, done, zero;
  logic [31:0] result;
  logic        start8 = 1'b0;
  logic [2:0]  op8 = 3'b000;
  logic [7:0]  a8 = 8'h0, b8 = 8'h0;
  logic        ready8, busy8, done8, zero8;
  logic [7:0]  result8;
`ifdef SEQ_LOGIC_UNIT_FLAGS_EN
  logic        parity, ones, parity8, ones8;
`endif

  int compared = 0;
  int mismatched = 0;

  seq_logic_unit #(.WIDTH(32), .SLICE(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .result(result), .zero(zero)
`ifdef SEQ_LOGIC_UNIT_FLAGS_EN
    , .parity(parity), .ones(ones)
`endif
  );

  seq_logic_unit #(.WIDTH(8), .SLICE(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .ready(ready8), .busy(busy8), .done(done8), .result(result8), .zero(zero8)
`ifdef SEQ_LOGIC_UNIT_FLAGS_EN
    , .parity(parity8), .ones(ones8)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one operation on the 32-bit unit; lat counts edges from start driven to done seen.
  task automatic run32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output int busy_cnt, output bit seen);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    lat = 0; busy_cnt = 0; seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
    end
  endtask

  initial begin
    int lat, bcnt, dcnt, rises, rdy_after;
    bit seen, prev_busy, prev_done;
    logic [31:0] res_at_done;
    int rise_t[3];

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'h0);
    check("rst_zero", 32'(zero), 32'd0);
    reset = 1'b0;

    // 1: AND, latency and busy duration
    run32(3'b001, 32'hF0F0_1234, 32'hFF00_FFFF, lat, bcnt, seen);
    check("t1_seen", 32'(seen), 32'd1);
    check("t1_lat", 32'(lat), 32'd9);
    check("t1_busy", 32'(bcnt), 32'd8);
    check("t1_result", result, 32'hF000_1234);
    check("t1_zero", 32'(zero), 32'd0);
`ifdef SEQ_LOGIC_UNIT_FLAGS_EN
    check("t1_parity", 32'(parity), 32'd1);
    check("t1_ones", 32'(ones), 32'd0);
`endif
    @(negedge clk);
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_ready_after", 32'(ready), 32'd1);
    check("t1_hold", result, 32'hF000_1234);

    // 2: XOR of equal operands gives zero
    run32(3'b011, 32'hDEAD_BEEF, 32'hDEAD_BEEF, lat, bcnt, seen);
    check("t2_result", result, 32'h0);
    check("t2_zero", 32'(zero), 32'd1);
`ifdef SEQ_LOGIC_UNIT_FLAGS_EN
    check("t2_parity", 32'(parity), 32'd0);
    check("t2_ones", 32'(ones), 32'd0);
`endif

    // 3: NOT of zero, zero flag cleared by the accepted start
    @(negedge clk);
    start = 1'b1; op = 3'b000; a = 32'h0; b = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    check("t3_zero_cleared", 32'(zero), 32'd0);
    check("t3_result_cleared", result, 32'h0);
    repeat (8) @(negedge clk);
    check("t3_done", 32'(done), 32'd1);
    check("t3_result", result, 32'hFFFF_FFFF);
    check("t3_zero", 32'(zero), 32'd0);
`ifdef SEQ_LOGIC_UNIT_FLAGS_EN
    check("t3_parity", 32'(parity), 32'd0);
    check("t3_ones", 32'(ones), 32'd1);
`endif
    run32(3'b111, 32'hFFFF_FFFF, 32'h0F0F_0F0F, lat, bcnt, seen);
    check("t3b_result", result, 32'hF0F0_F0F0);

    // 4: inputs churn during RUN
    @(negedge clk);
    start = 1'b1; op = 3'b110; a = 32'h1; b = 32'h2;
    dcnt = 0; res_at_done = 32'h0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (done) begin
        dcnt++;
        res_at_done = result;
      end
      if (busy) begin
        start = ~start; a = $urandom; b = $urandom; op = 3'(op + 3'd1);
      end else begin
        start = 1'b0;
      end
    end
    check("t4_done_count", 32'(dcnt), 32'd1);
    check("t4_result", res_at_done, 32'hFFFF_FFFC);

    // 5: reset during the 4th RUN cycle aborts without a done pulse
    @(negedge clk);
    start = 1'b1; op = 3'b001; a = 32'hF0F0_1234; b = 32'hFF00_FFFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_ready", 32'(ready), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_result", result, 32'h0);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("t5_no_done", 32'(dcnt), 32'd0);
    run32(3'b010, 32'h0000_00F0, 32'h0000_000F, lat, bcnt, seen);
    check("t5_seen", 32'(seen), 32'd1);
    check("t5_result_or", result, 32'h0000_00FF);

    // 6: start held high across three operations
    @(negedge clk);
    start = 1'b1; op = 3'b001; a = 32'hF0F0_1234; b = 32'hFF00_FFFF;
    rises = 0; dcnt = 0; rdy_after = 0; prev_busy = 1'b0; prev_done = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (busy && !prev_busy && rises < 3) begin
        rise_t[rises] = i;
        rises++;
      end
      if (done) dcnt++;
      if (prev_done && ready) rdy_after++;
      prev_busy = busy;
      prev_done = done;
      if (i == 29) start = 1'b0;
    end
    check("t6_rises", 32'(rises), 32'd3);
    check("t6_dones", 32'(dcnt), 32'd3);
    check("t6_done_ignores_start", 32'(rdy_after), 32'd3);
    check("t6_gap1", 32'(rise_t[1] - rise_t[0]), 32'd10);
    check("t6_gap2", 32'(rise_t[2] - rise_t[1]), 32'd10);
    check("t6_result", result, 32'hF000_1234);

    // 6b: single-slice instance, NAND
    @(negedge clk);
    start8 = 1'b1; op8 = 3'b101; a8 = 8'hFF; b8 = 8'h0F;
    lat = 0; bcnt = 0; seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      start8 = 1'b0;
      lat++;
      if (busy8) bcnt++;
      if (done8) seen = 1'b1;
    end
    check("t6b_seen", 32'(seen), 32'd1);
    check("t6b_lat", 32'(lat), 32'd2);
    check("t6b_busy", 32'(bcnt), 32'd1);
    check("t6b_result", 32'(result8), 32'h0000_00F0);
    check("t6b_zero", 32'(zero8), 32'd0);
    @(negedge clk);
    check("t6b_ready", 32'(ready8), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
